// File: rtl/div_iter_unit.sv
// ---------------------------------------------------------------------------
// div_iter_unit
//
// Iterative 32-bit restoring radix-2 divider for the execute-stage ALU.
// Handles DIV (signed) and DIVU (unsigned) in one datapath by dividing
// magnitudes and fixing up the signs on the final iteration. One quotient
// bit is produced per cycle, so a result appears 33 cycles after acceptance.
//
// Ports
//   clk        : rising-edge clock
//   resetn     : asynchronous active-low reset
//   flush      : synchronous abort, forces IDLE and discards the operation
//   data_valid : request level, held high by the ALU while it stalls
//   is_signed  : 1 = DIV, 0 = DIVU (sampled with the operands)
//   src1       : dividend (sampled on acceptance only)
//   src2       : divisor  (sampled on acceptance only)
//   div_out    : {quotient, remainder}, meaningful while res_valid is high
//   res_valid  : one-cycle result pulse (state == DONE)
//   busy       : high whenever the unit is not IDLE
// ---------------------------------------------------------------------------
module div_iter_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        data_valid,
  input  logic        is_signed,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic [63:0] div_out,
  output logic        res_valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg;
  logic [31:0] divisor_reg;   // divisor magnitude
  logic [31:0] rem_reg;       // partial remainder (its 33rd bit is always 0, so it is not stored)
  logic [31:0] quo_reg;       // dividend shifts out of the top, quotient shifts in at the bottom
  logic [4:0]  cnt_reg;
  logic        q_neg_reg;
  logic        r_neg_reg;
  logic        div0_reg;
  logic [31:0] src1_orig_reg; // raw dividend, returned as the remainder on divide-by-zero
  logic [63:0] div_out_reg;

  // Acceptance-time operand magnitudes. 0x80000000 negates to itself, which
  // is exactly the unsigned magnitude we want.
  logic [31:0] src1_mag;
  logic [31:0] src2_mag;

  // One restoring iteration
  logic [32:0] shifted;
  logic [32:0] trial;
  logic [31:0] rem_step;
  logic [31:0] quo_step;

  // Final signed correction applied on the last iteration
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [63:0] result_next;

  always_comb begin
    src1_mag = (is_signed && src1[31]) ? (32'd0 - src1) : src1;
    src2_mag = (is_signed && src2[31]) ? (32'd0 - src2) : src2;
  end

  always_comb begin
    shifted  = {rem_reg, quo_reg[31]};
    trial    = shifted - {1'b0, divisor_reg};
    rem_step = shifted[31:0];
    quo_step = {quo_reg[30:0], 1'b0};
    // Top bit clear means the divisor fits: keep the subtraction.
    if (!trial[32]) begin
      rem_step = trial[31:0];
      quo_step = {quo_reg[30:0], 1'b1};
    end
  end

  always_comb begin
    quo_fix = q_neg_reg ? (32'd0 - quo_step) : quo_step;
    rem_fix = r_neg_reg ? (32'd0 - rem_step) : rem_step;
    // Divide-by-zero ignores the iteration result entirely and is never
    // sign-corrected.
    result_next = div0_reg ? {32'hFFFF_FFFF, src1_orig_reg} : {quo_fix, rem_fix};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      divisor_reg   <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      cnt_reg       <= '0;
      q_neg_reg     <= 1'b0;
      r_neg_reg     <= 1'b0;
      div0_reg      <= 1'b0;
      src1_orig_reg <= '0;
      div_out_reg   <= '0;
    end else if (flush) begin
      // Abort wins over everything, including a pending request in IDLE.
      // div_out is deliberately left untouched.
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (data_valid) begin
            state_reg     <= CALC;
            divisor_reg   <= src2_mag;
            rem_reg       <= '0;
            quo_reg       <= src1_mag;
            cnt_reg       <= '0;
            q_neg_reg     <= is_signed & (src1[31] ^ src2[31]);
            r_neg_reg     <= is_signed & src1[31];
            div0_reg      <= (src2 == 32'd0);
            src1_orig_reg <= src1;
          end
        end
        CALC: begin
          rem_reg <= rem_step;
          quo_reg <= quo_step;
          cnt_reg <= cnt_reg + 5'd1;
          if (cnt_reg == 5'd31) begin
            div_out_reg <= result_next;
            state_reg   <= DONE;
          end
        end
        DONE: begin
          // The request line is not looked at here; a still-high
          // data_valid is taken as the next instruction's request in IDLE.
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign div_out   = div_out_reg;
  assign res_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_div_iter_unit.sv
module tb_div_iter_unit;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        data_valid;
  logic        is_signed;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [63:0] div_out;
  logic        res_valid;
  logic        busy;

  div_iter_unit dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .data_valid (data_valid),
    .is_signed  (is_signed),
    .src1       (src1),
    .src2       (src2),
    .div_out    (div_out),
    .res_valid  (res_valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running edge counter, read only on falling edges.
  int unsigned cyc;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] val;
    int unsigned cyc;
    int          id;
  } exp_t;

  exp_t sb_q[$];
  int   tests;
  int   fails;
  int   op_id;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end else begin
      $display("[TB] ok   %s: %h", name, act);
    end
  endtask

  // Monitor: every result pulse pops the oldest expectation and checks
  // value, arrival cycle and that busy is still asserted.
  always @(negedge clk) begin
    if (resetn && res_valid) begin
      exp_t e;
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_result: got %h at cycle %0d, expected no result", div_out, cyc);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("op%0d_value", e.id), div_out, e.val);
        check($sformatf("op%0d_cycle", e.id), 64'(cyc), 64'(e.cyc));
        check($sformatf("op%0d_busy", e.id), 64'(busy), 64'd1);
      end
    end
  end

  // Called just after a falling edge: presents a request that the next
  // rising edge accepts. The result is due 33 edges after that one.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp_val, input bit push);
    exp_t e;
    src1       = a;
    src2       = b;
    is_signed  = s;
    data_valid = 1'b1;
    op_id++;
    if (push) begin
      e.val = exp_val;
      e.cyc = cyc + 33;
      e.id  = op_id;
      sb_q.push_back(e);
    end
  endtask

  // After the accepting edge: drop the request and scramble operands.
  task automatic release_req();
    @(negedge clk);
    data_valid = 1'b0;
    src1       = $urandom;
    src2       = $urandom;
    is_signed  = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("[TB] FAIL wait_idle: busy still 1 after %0d cycles, expected 0", n);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [63:0] exp_val);
    start_op(a, b, s, exp_val, 1'b1);
    release_req();
    wait_idle();
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    op_id      = 0;
    resetn     = 1'b0;
    flush      = 1'b0;
    data_valid = 1'b0;
    is_signed  = 1'b0;
    src1       = '0;
    src2       = '0;

    repeat (3) @(negedge clk);
    check("reset_div_out", div_out, 64'd0);
    check("reset_res_valid", 64'(res_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    resetn = 1'b1;

    // 100 / 7 unsigned with busy sampled during the operation
    start_op(32'd100, 32'd7, 1'b0, {32'h0000000E, 32'h00000002}, 1'b1);
    release_req();
    check("busy_cycle1", 64'(busy), 64'd1);
    wait_idle();
    check("busy_after_done", 64'(busy), 64'd0);

    // Signed and unsigned corner cases
    run_op(32'hFFFFFFF9, 32'd2,        1'b1, {32'hFFFFFFFD, 32'hFFFFFFFF}); // -7 / 2
    run_op(32'd7,        32'hFFFFFFFE, 1'b1, {32'hFFFFFFFD, 32'h00000001}); // 7 / -2
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h80000000, 32'h00000000}); // overflow
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b0, {32'h00000000, 32'h80000000});
    run_op(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, {32'h0000000E, 32'hFFFFFFFE}); // -100 / -7
    run_op(32'hFFFFFFF9, 32'd2,        1'b0, {32'h7FFFFFFC, 32'h00000001});

    // Divide by zero, no sign correction even for a negative dividend
    run_op(32'h12345678, 32'd0, 1'b1, {32'hFFFFFFFF, 32'h12345678});
    run_op(32'h12345678, 32'd0, 1'b0, {32'hFFFFFFFF, 32'h12345678});
    run_op(32'h87654321, 32'd0, 1'b1, {32'hFFFFFFFF, 32'h87654321});

    // Flush in cycle 10 of 1000/3, then 6/3 accepted on the next edge
    start_op(32'd1000, 32'd3, 1'b0, 64'd0, 1'b0);
    release_req();
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_div_out_held", div_out, {32'hFFFFFFFF, 32'h87654321});
    check("flush_busy", 64'(busy), 64'd0);
    run_op(32'd6, 32'd3, 1'b0, {32'd2, 32'd0});

    // Flush with a request in IDLE: nothing accepted
    data_valid = 1'b1;
    src1       = 32'd40;
    src2       = 32'd4;
    flush      = 1'b1;
    @(negedge clk);
    flush      = 1'b0;
    data_valid = 1'b0;
    check("flush_idle_busy", 64'(busy), 64'd0);

    // Back-to-back with data_valid continuously high
    start_op(32'hFFFFFFFF, 32'd16, 1'b0, {32'h0FFFFFFF, 32'h0000000F}, 1'b1);
    begin
      exp_t e2;
      e2.val = {32'd10, 32'd0};
      e2.cyc = cyc + 67;
      e2.id  = 100;
      sb_q.push_back(e2);
    end
    @(negedge clk);
    src1 = 32'd50;
    src2 = 32'd5;
    repeat (34) @(negedge clk);
    data_valid = 1'b0;
    wait_idle();

    // Asynchronous reset in cycle 20, then 9/4 at standard latency
    start_op(32'd1000, 32'd7, 1'b0, 64'd0, 1'b0);
    release_req();
    repeat (19) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_div_out", div_out, 64'd0);
    check("async_rst_res_valid", 64'(res_valid), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_op(32'd9, 32'd4, 1'b0, {32'd2, 32'd1});

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/div_iter_unit.md
# div_iter_unit

Iterative 32-bit radix-2 divider serving the execute-stage ALU as the responder of its divide handshake. The ALU holds a request level-high, stalling the pipeline, until this block pulses a result-valid. The block then returns the quotient and remainder, which the ALU writes to LO and HI. It handles both DIV (signed) and DIVU (unsigned) in one datapath and can be aborted by the pipeline flush on exceptions.

## Interface
- No parameters; width fixed at 32.
- `clk` in 1: sole clock, rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `flush` in 1: synchronous abort from exception/ERET flush; discards any operation.
- `data_valid` in 1: request level, held high by the ALU while a div/divu is in EX and stalled.
- `is_signed` in 1: 1 = DIV semantics, 0 = DIVU; sampled with operands.
- `src1` in 32: dividend; sampled on acceptance only.
- `src2` in 32: divisor; sampled on acceptance only.
- `div_out` out 64: `{quotient[31:0], remainder[31:0]}`, registered; valid while `res_valid`=1.
- `res_valid` out 1: one-cycle result pulse.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, CALC, DONE.
  - IDLE: if `data_valid` & ~`flush`, accept the request and go to CALC.
  - CALC: performs 32 iterations, one per cycle, then goes to DONE.
  - DONE: unconditionally returns to IDLE.
- Acceptance, on the IDLE edge:
  - Latch `|src1|` and `|src2|` as 32-bit magnitudes. Magnitudes are taken only when `is_signed`; 0x80000000 maps to magnitude 0x80000000.
  - Latch sign flags: `q_neg = is_signed & (src1[31]^src2[31])`, `r_neg = is_signed & src1[31]`.
  - Latch a `div0` flag: `src2`==0.
  - Clear the 33-bit partial remainder, load the 32-bit quotient shift register with the dividend magnitude, and clear the 5-bit iteration counter.
- CALC iteration (restoring):
  - Form `trial = {rem[31:0], q[31]} - {1'b0, divisor}` (33-bit).
  - If `trial` is non-negative: `rem = trial` and shift 1 into the quotient LSB.
  - Otherwise: `rem = {rem[31:0], q[31]}` and shift 0 into the quotient LSB.
  - The counter increments each iteration. After iteration 31 (counter==31), load `div_out` and go to DONE.
- Result correction on the CALC→DONE edge:
  - Quotient is negated if `q_neg`; remainder is negated if `r_neg`.
  - Remainder sign always follows the dividend; `|remainder| < |divisor|`.
- Divide by zero: `div_out` = {32'hFFFFFFFF, original `src1`}, with no sign correction. Latency is the same as a normal divide.
- Overflow case: 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000, remainder 0, with no fault.
- `div_out` holds its value after DONE until the next completion; it has no meaning outside `res_valid`.

## Timing
- Reset (`resetn`=0, any time, including mid-CALC):
  - State goes to IDLE immediately, asynchronously.
  - `res_valid`=0, `busy`=0, `div_out`=0, and all internal registers are cleared.
  - The first acceptance is possible on the first edge after release.
- Latency:
  - Request accepted at edge E0 (cycle 0).
  - CALC occupies cycles 1–32.
  - `res_valid`=1 throughout cycle 33, with `div_out` valid.
  - The ALU observes 33 stall cycles (0–32) and advances at the end of cycle 33.
- `res_valid` is exactly one cycle wide and is decoded from state==DONE.
- Back-to-back requests:
  - `data_valid` still high in the cycle after DONE is treated as a new request from the next instruction.
  - It is accepted on that IDLE edge (cycle 34), so there is a one-cycle minimum gap between operations.
  - `data_valid` is never sampled while in CALC or DONE.
- Flush:
  - `flush`=1 at any edge forces IDLE.
  - CALC progress is discarded; `res_valid` stays 0 and `div_out` is not updated.
  - `flush` in DONE: `res_valid` is still 1 during that cycle (combinational from state); the ALU ignores it under flush.
  - `flush` with `data_valid` in IDLE: flush wins and nothing is accepted.
- Operands may change after acceptance without affecting the result.

## Test plan
- Unsigned 100 / 7 (`is_signed`=0), `data_valid` held: `res_valid` pulses in cycle 33 only, with `div_out` = {0x0000000E, 0x00000002}; `busy` is high in cycles 1–33.
- Signed cases:
  - -7 / 2 → {0xFFFFFFFD, 0xFFFFFFFF}.
  - 7 / -2 → {0xFFFFFFFD, 0x00000001}.
  - 0x80000000 / 0xFFFFFFFF → {0x80000000, 0x00000000}.
- Divide by zero: 0x12345678 / 0 (signed and unsigned) → {0xFFFFFFFF, 0x12345678} in cycle 33.
- Flush then recover: `flush` pulsed in cycle 10 of a 1000/3 divide → no `res_valid`, and `div_out` keeps its prior value. A 6/3 request accepted next cycle → {2, 0} exactly 33 cycles after acceptance.
- Back-to-back: 0xFFFFFFFF / 16 unsigned followed by 50 / 5 with `data_valid` continuously high → results {0x0FFFFFFF, 0xF} at cycle 33 and {10, 0} at cycle 67.
- Reset mid-operation: `resetn` low in cycle 20 → outputs go to 0 asynchronously (before the next edge). After release, a 9/4 request completes with {2, 1} at standard latency.
